// File: rtl/fir_out_decimator_if.sv
//------------------------------------------------------------------------------
// fir_out_decimator_if
//   Valid/ready output stream of the FIR output decimator.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fir_out_decimator_if #(
  parameter int OUT_WIDTH = 8
);
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

`default_nettype wire

// File: rtl/fir_out_decimator.sv
//------------------------------------------------------------------------------
// fir_out_decimator
//   Keeps 1 of DECIM filter samples, scales by 2^-SHIFT, saturates to
//   OUT_WIDTH bits and buffers results in a DEPTH-entry FIFO.
//   Optional round-half-up scaling: define FIR_DEC_ROUND_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_out_decimator #(
  parameter int IN_WIDTH  = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 10,
  parameter int DECIM     = 4,
  parameter int DEPTH     = 4
) (
  input  wire logic                   CLK_Filter,
  input  wire logic                   rst,
  input  wire logic [IN_WIDTH-1:0]    sample_in,
  input  wire logic                   sample_valid,
  fir_out_decimator_if.master         m_if,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        sat_flag,
  output logic                        ovf_flag,
  input  wire logic                   flag_clr
);

  localparam int c_PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [c_PH_W-1:0]  c_PH_LAST = c_PH_W'(DECIM - 1);
  localparam logic [IN_WIDTH:0]  c_MAX     = (IN_WIDTH+1)'((1 << OUT_WIDTH) - 1);
  localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(DEPTH);
`ifdef FIR_DEC_ROUND_EN
  localparam logic [IN_WIDTH:0]  c_RND     = (IN_WIDTH+1)'(1) << (SHIFT - 1);
`else
  localparam logic [IN_WIDTH:0]  c_RND     = '0;
`endif

  logic [c_PH_W-1:0]    r_phase;
  logic [IN_WIDTH-1:0]  r_in_data;
  logic                 r_in_valid;
  logic [OUT_WIDTH-1:0] r_s1_data;
  logic                 r_s1_valid;
  logic [OUT_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_level;

  logic                 w_keep;
  logic [IN_WIDTH:0]    w_sum;
  logic [IN_WIDTH:0]    w_shr;
  logic                 w_sat;
  logic [OUT_WIDTH-1:0] w_q;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_keep = sample_valid && (r_phase == '0);

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      r_phase <= '0;
    end else if (sample_valid) begin
      r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_W'(1);
    end
  end

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
    end else begin
      r_in_valid <= w_keep;
      if (w_keep) begin
        r_in_data <= sample_in;
      end
    end
  end

  // One extra bit of headroom so the rounding offset never wraps.
  assign w_sum = {1'b0, r_in_data} + c_RND;
  assign w_shr = w_sum >> SHIFT;
  assign w_sat = (w_shr > c_MAX);
  assign w_q   = w_sat ? '1 : w_shr[OUT_WIDTH-1:0];

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_in_valid;
      if (r_in_valid) begin
        r_s1_data <= w_q;
      end
    end
  end

  assign w_full = (r_level == c_FULL);
  assign w_pop  = (r_level != '0) && m_if.m_ready;
  assign w_push = r_s1_valid && (!w_full || w_pop);
  assign w_drop = r_s1_valid && w_full && !w_pop;

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_s1_data;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle overrides the clear.
  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (r_in_valid && w_sat) begin
        sat_flag <= 1'b1;
      end else if (flag_clr) begin
        sat_flag <= 1'b0;
      end
      if (w_drop) begin
        ovf_flag <= 1'b1;
      end else if (flag_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  assign m_if.m_data  = r_mem[r_rd_ptr];
  assign m_if.m_valid = (r_level != '0);
  assign fifo_level   = r_level;

endmodule

`default_nettype wire

// File: tb/tb_fir_out_decimator.sv
// Scoreboard bench for fir_out_decimator: a DECIM=4 instance for the main
// scenarios and a DECIM=1 instance for full-FIFO streaming.
`default_nettype none

module tb_fir_out_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_clr;
  logic [19:0] sample_in, sample2;
  logic        sample_valid, valid2;
  logic [2:0]  fifo_level, level2;
  logic        sat_flag, ovf_flag, sat2, ovf2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  fir_out_decimator_if #(.OUT_WIDTH(8)) if1();
  fir_out_decimator_if #(.OUT_WIDTH(8)) if2();

  fir_out_decimator #(.IN_WIDTH(20), .OUT_WIDTH(8), .SHIFT(10), .DECIM(4), .DEPTH(4)) u_dut (
    .CLK_Filter(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .m_if(if1), .fifo_level(fifo_level), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
    .flag_clr(flag_clr)
  );

  fir_out_decimator #(.IN_WIDTH(20), .OUT_WIDTH(8), .SHIFT(10), .DECIM(1), .DEPTH(4)) u_dut1 (
    .CLK_Filter(clk), .rst(rst), .sample_in(sample2), .sample_valid(valid2),
    .m_if(if2), .fifo_level(level2), .sat_flag(sat2), .ovf_flag(ovf2),
    .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One kept sample followed by three discarded fillers.
  task automatic keep4(input logic [19:0] s, input logic [7:0] e, input bit push_exp);
    sample_in    = s;
    sample_valid = 1'b1;
    if (push_exp) q1.push_back(e);
    tick();
    for (int i = 0; i < 3; i++) begin
      sample_in = 20'd0;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && if1.m_valid && if1.m_ready) begin
      if (q1.size() == 0) begin
        check("dut_unexpected_out", int'(if1.m_data), -1);
      end else begin
        check("dut_m_data", int'(if1.m_data), int'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if2.m_valid && if2.m_ready) begin
      if (q2.size() == 0) begin
        check("dut1_unexpected_out", int'(if2.m_data), -1);
      end else begin
        check("dut1_m_data", int'(if2.m_data), int'(q2.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flag_clr = 1'b0;
    sample_in = '0; sample_valid = 1'b0; if1.m_ready = 1'b1;
    sample2 = '0; valid2 = 1'b0; if2.m_ready = 1'b0;
    tick(); tick();
    check("reset_m_valid", int'(if1.m_valid), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_m_data", int'(if1.m_data), 0);
    check("reset_flags", int'({sat_flag, ovf_flag}), 0);
    rst = 1'b0;

    // Continuous 102400 -> 100 every fourth sample; 3-edge latency.
    for (int i = 0; i < 12; i++) begin
      sample_in = 20'd102400; sample_valid = 1'b1;
      if (i % 4 == 0) q1.push_back(8'd100);
      tick();
      if (i == 0) check("latency_edge_n", int'(if1.m_valid), 0);
      if (i == 1) check("latency_edge_n1", int'(if1.m_valid), 0);
      if (i == 2) check("latency_edge_n2", int'(if1.m_valid), 1);
    end
    sample_valid = 1'b0;
    repeat (4) tick();
    check("stream_sat_flag", int'(sat_flag), 0);
    check("stream_level", int'(fifo_level), 0);

    // Saturation and flag clear.
    keep4(20'd353940, 8'd255, 1'b1);
    tick(); tick();
    check("sat_flag_set", int'(sat_flag), 1);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    check("sat_flag_clr", int'(sat_flag), 0);

    // Rounding boundary.
`ifdef FIR_DEC_ROUND_EN
    keep4(20'd1536, 8'd2, 1'b1);
`else
    keep4(20'd1536, 8'd1, 1'b1);
`endif
    keep4(20'd1535, 8'd1, 1'b1);
    repeat (3) tick();

    // Overflow with backpressure, then in-order drain.
    if1.m_ready = 1'b0;
    for (int v = 10; v <= 60; v += 10) keep4(20'(v * 1024), 8'(v), v <= 40);
    tick(); tick();
    check("full_level", int'(fifo_level), 4);
    check("full_ovf_flag", int'(ovf_flag), 1);
    check("full_head_stable", int'(if1.m_data), 10);
    if1.m_ready = 1'b1;
    repeat (6) tick();
    check("drain_m_valid", int'(if1.m_valid), 0);
    check("drain_level", int'(fifo_level), 0);
    check("drain_sb_empty", q1.size(), 0);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    check("ovf_flag_clr", int'(ovf_flag), 0);

    // Reset mid-traffic with data buffered, in flight and phase non-zero.
    if1.m_ready = 1'b0;
    keep4(20'd353940, 8'd0, 1'b0);
    sample_in = 20'd1024; sample_valid = 1'b1;
    tick(); tick();
    sample_valid = 1'b0; rst = 1'b1;
    tick(); tick();
    check("midrst_m_valid", int'(if1.m_valid), 0);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_flags", int'({sat_flag, ovf_flag}), 0);
    rst = 1'b0; if1.m_ready = 1'b1;
    sample_in = 20'd7168; sample_valid = 1'b1; q1.push_back(8'd7);
    tick();
    sample_valid = 1'b0;
    repeat (5) tick();
    check("midrst_first_kept", q1.size(), 0);

    // DECIM=1: fill to 4, then stream with push+pop every cycle.
    for (int k = 1; k <= 4; k++) begin
      sample2 = 20'(k * 1024); valid2 = 1'b1; q2.push_back(8'(k));
      tick();
    end
    valid2 = 1'b0;
    repeat (3) tick();
    check("d1_fill_level", int'(level2), 4);
    for (int k = 5; k <= 12; k++) begin
      sample2 = 20'(k * 1024); valid2 = 1'b1; q2.push_back(8'(k));
      if (k == 7) if2.m_ready = 1'b1;
      tick();
      check("d1_stream_level", int'(level2), 4);
      check("d1_stream_ovf", int'(ovf2), 0);
    end
    valid2 = 1'b0;
    repeat (10) tick();
    check("d1_drain_level", int'(level2), 0);
    check("d1_sb_empty", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
